conv_channel_sequencer: RTL and testbench
=========================================

// Module: conv_channel_sequencer
// PURPOSE
//  Sequences one convolution layer over all output/input channel pairs. Issues per-channel
//  load, conv, adder-tree and optional pool commands to the layer datapath, and waits on
//  the datapath's done handshakes. Sits between the network-level controller (start/done)
//  and the conv/pool engines. A watchdog flags a hung engine; abort returns it to idle.
// PARAMETERS
//  IC    4    input channels per output channel (>=1)
//  OC    8    output channels per layer (>=1)
//  WDOG  1024 max cycles waiting on conv_done/pool_done; 0 disables the watchdog
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst_n       in   1       synchronous active-low reset
//  start       in   1       begin layer; sampled only in IDLE
//  pool_en     in   1       enable pooling per output channel; latched when start accepted
//  abort       in   1       force return to IDLE from any state
//  conv_done   in   1       conv engine finished current ic (sampled only in WAIT_C)
//  pool_done   in   1       pool engine finished current oc (sampled only in WAIT_P)
//  c_load      out  1       1-cycle pulse: load bias/kernels for oc_idx
//  conv        out  1       1-cycle pulse: start conv of (oc_idx, ic_idx)
//  tree        out  1       1-cycle pulse: reduce IC partial sums through the adder tree
//  pool        out  1       1-cycle pulse: start pooling for oc_idx
//  cout_done   out  1       1-cycle pulse: output channel oc_idx complete
//  ic_idx      out  ICW     current input channel, ICW = max(1,$clog2(IC))
//  oc_idx      out  OCW     current output channel, OCW = max(1,$clog2(OC))
//  busy        out  1       high in every state except IDLE
//  done        out  1       1-cycle pulse: layer complete
//  err         out  1       watchdog timeout; held until abort or reset
// BEHAVIOUR
//  Reset: state=IDLE; all pulses, busy, done, err=0; ic_idx=oc_idx=0; pool_en_q=0; wdog=0.
//  All outputs registered (Moore); a pulse is high exactly while its state is current.
//  States/transitions:
//   IDLE  : start=1 -> LOAD; latch pool_en; ic=0, oc=0. start while busy is ignored.
//   LOAD  : c_load=1 -> CONV.
//   CONV  : conv=1 -> WAIT_C; wdog cleared.
//   WAIT_C: conv_done=1 -> (ic==IC-1 ? TREE : ic++, CONV). conv_done outside WAIT_C ignored.
//   TREE  : tree=1 -> (pool_en_q ? POOL : NEXT).
//   POOL  : pool=1 -> WAIT_P; wdog cleared.
//   WAIT_P: pool_done=1 -> NEXT.
//   NEXT  : cout_done=1; ic=0 -> (oc==OC-1 ? DONE : oc++, LOAD).
//   DONE  : done=1 -> IDLE (oc_idx/ic_idx return to 0).
//   ERR   : err=1, busy=1; leaves only on abort or reset.
//  Watchdog: in WAIT_C/WAIT_P wdog increments each cycle without the done input; when wdog
//   reaches WDOG-1 and done still low -> ERR next cycle. Done on that same cycle wins.
//  abort: highest priority after reset; any state -> IDLE next cycle, indices/err cleared,
//   no done or cout_done emitted. abort and start together in IDLE -> stay IDLE.
//  Index wrap: ic never exceeds IC-1, oc never exceeds OC-1; IC=1 gives one CONV per oc.
//  Latency (IC=1, OC=1, pool off, conv_done 1 cycle after conv): start at cycle 0 ->
//   LOAD 1, CONV 2, WAIT_C 3, TREE 4, NEXT 5, DONE 6 (done high), IDLE 7.
//  Total conv pulses per layer = IC*OC; cout_done pulses = OC; pool pulses = OC*pool_en_q.
//  pool_en changes while busy have no effect.
// TESTING
//  1 Reset: rst_n=0 two cycles mid-WAIT_C -> all outputs 0, state IDLE, indices 0.
//  2 IC=1,OC=1,pool_en=0, conv_done 1 cycle after conv -> done high exactly 6 cycles after start.
//  3 IC=4,OC=8,pool_en=1, random 1-20 cycle done delays -> 32 conv, 8 tree, 8 pool, 8 cout_done,
//    1 done; ic_idx sequence 0..3 per oc, oc_idx 0..7 in order.
//  4 conv_done held high continuously incl. during CONV/LOAD -> still exactly one ic step per WAIT_C.
//  5 WDOG=16, conv_done never asserted -> err=1 16 cycles after entering WAIT_C; abort -> IDLE, err=0.
//  6 abort during WAIT_P at oc=3 -> IDLE next cycle, no done/cout_done; new start runs full layer.

Source files
------------

// File: rtl/conv_channel_sequencer.sv
// conv_channel_sequencer
//   Walks one convolution layer over every (output channel, input channel) pair and
//   issues load / conv / adder-tree / pool commands to the layer datapath, waiting on
//   the engines' done handshakes. A watchdog traps a hung engine in ERR until abort.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start, pool_en       layer kick-off (IDLE only); pool_en captured with start
//   abort                return to IDLE from any state
//   conv_done, pool_done engine handshakes, honoured only in WAIT_C / WAIT_P
//   c_load, conv, tree,  one-cycle command pulses
//   pool, cout_done, done
//   ic_idx, oc_idx       current input / output channel
//   busy, err            not-IDLE flag, watchdog trap flag
// All outputs come straight from flops (Moore); each pulse is high for the one cycle
// its state is current.
module conv_channel_sequencer #(
  parameter int IC   = 4,
  parameter int OC   = 8,
  parameter int WDOG = 1024,
  localparam int ICW = (IC > 1) ? $clog2(IC) : 1,
  localparam int OCW = (OC > 1) ? $clog2(OC) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           pool_en,
  input  logic           abort,
  input  logic           conv_done,
  input  logic           pool_done,
  output logic           c_load,
  output logic           conv,
  output logic           tree,
  output logic           pool,
  output logic           cout_done,
  output logic [ICW-1:0] ic_idx,
  output logic [OCW-1:0] oc_idx,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int WDW = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam logic [ICW-1:0] IC_LAST = ICW'(IC - 1);
  localparam logic [OCW-1:0] OC_LAST = OCW'(OC - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'((WDOG > 0) ? WDOG - 1 : 0);
  localparam bit             WD_EN   = (WDOG != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CONV, S_WAIT_C, S_TREE,
    S_POOL, S_WAIT_P, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [ICW-1:0]   ic_q, ic_d;
  logic [OCW-1:0]   oc_q, oc_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             pool_en_q, pool_en_d;
  logic             c_load_q, conv_q, tree_q, pool_q, cout_q, done_q, busy_q, err_q;
  logic             c_load_d, conv_d, tree_d, pool_d, cout_d, done_d, busy_d, err_d;
  logic             wd_hit;

  // Timeout fires on the last permitted cycle only if the handshake is still low;
  // a done arriving on that same cycle takes priority in the wait states below.
  assign wd_hit = WD_EN && (wdog_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    oc_d      = oc_q;
    wdog_d    = wdog_q;
    pool_en_d = pool_en_q;
    if (abort) begin
      state_d = S_IDLE;
      ic_d    = '0;
      oc_d    = '0;
      wdog_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d   = S_LOAD;
          pool_en_d = pool_en;
          ic_d      = '0;
          oc_d      = '0;
        end
        S_LOAD: state_d = S_CONV;
        S_CONV: begin
          state_d = S_WAIT_C;
          wdog_d  = '0;
        end
        S_WAIT_C: begin
          if (conv_done) begin
            if (ic_q == IC_LAST) state_d = S_TREE;
            else begin
              ic_d    = ic_q + ICW'(1);
              state_d = S_CONV;
            end
          end else if (wd_hit) state_d = S_ERR;
          else wdog_d = wdog_q + WDW'(1);
        end
        S_TREE: state_d = pool_en_q ? S_POOL : S_NEXT;
        S_POOL: begin
          state_d = S_WAIT_P;
          wdog_d  = '0;
        end
        S_WAIT_P: begin
          if (pool_done) state_d = S_NEXT;
          else if (wd_hit) state_d = S_ERR;
          else wdog_d = wdog_q + WDW'(1);
        end
        S_NEXT: begin
          ic_d = '0;
          if (oc_q == OC_LAST) state_d = S_DONE;
          else begin
            oc_d    = oc_q + OCW'(1);
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          ic_d    = '0;
          oc_d    = '0;
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    c_load_d = (state_d == S_LOAD);
    conv_d   = (state_d == S_CONV);
    tree_d   = (state_d == S_TREE);
    pool_d   = (state_d == S_POOL);
    cout_d   = (state_d == S_NEXT);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
    err_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ic_q      <= '0;
      oc_q      <= '0;
      wdog_q    <= '0;
      pool_en_q <= 1'b0;
      c_load_q  <= 1'b0;
      conv_q    <= 1'b0;
      tree_q    <= 1'b0;
      pool_q    <= 1'b0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ic_q      <= ic_d;
      oc_q      <= oc_d;
      wdog_q    <= wdog_d;
      pool_en_q <= pool_en_d;
      c_load_q  <= c_load_d;
      conv_q    <= conv_d;
      tree_q    <= tree_d;
      pool_q    <= pool_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign c_load    = c_load_q;
  assign conv      = conv_q;
  assign tree      = tree_q;
  assign pool      = pool_q;
  assign cout_done = cout_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign ic_idx    = ic_q;
  assign oc_idx    = oc_q;

endmodule

// File: tb/tb_conv_channel_sequencer.sv
// Bench for conv_channel_sequencer.
//   u_a: IC=4, OC=8, WDOG=1024 -- full layers, scoreboarded command stream, reset, abort.
//   u_b: IC=1, OC=1, WDOG=16   -- cycle-exact vector table and watchdog corner cases.
module tb_conv_channel_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic a_start = 1'b0, a_pool_en = 1'b0, a_abort = 1'b0;
  logic a_conv_done = 1'b0, a_pool_done = 1'b0;
  logic a_c_load, a_conv, a_tree, a_pool, a_cout_done, a_busy, a_done, a_err;
  logic [1:0] a_ic_idx;
  logic [2:0] a_oc_idx;
  logic [7:0] a_vec;
  assign a_vec = {a_c_load, a_conv, a_tree, a_pool, a_cout_done, a_done, a_busy, a_err};

  conv_channel_sequencer #(.IC(4), .OC(8), .WDOG(1024)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .pool_en(a_pool_en), .abort(a_abort),
    .conv_done(a_conv_done), .pool_done(a_pool_done), .c_load(a_c_load), .conv(a_conv),
    .tree(a_tree), .pool(a_pool), .cout_done(a_cout_done), .ic_idx(a_ic_idx),
    .oc_idx(a_oc_idx), .busy(a_busy), .done(a_done), .err(a_err));

  // ---------------- instance B ----------------
  logic b_start = 1'b0, b_pool_en = 1'b0, b_abort = 1'b0;
  logic b_conv_done = 1'b0, b_pool_done = 1'b0;
  logic b_c_load, b_conv, b_tree, b_pool, b_cout_done, b_busy, b_done, b_err;
  logic [0:0] b_ic_idx, b_oc_idx;
  logic [7:0] b_vec;
  assign b_vec = {b_c_load, b_conv, b_tree, b_pool, b_cout_done, b_done, b_busy, b_err};

  conv_channel_sequencer #(.IC(1), .OC(1), .WDOG(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pool_en(b_pool_en), .abort(b_abort),
    .conv_done(b_conv_done), .pool_done(b_pool_done), .c_load(b_c_load), .conv(b_conv),
    .tree(b_tree), .pool(b_pool), .cout_done(b_cout_done), .ic_idx(b_ic_idx),
    .oc_idx(b_oc_idx), .busy(b_busy), .done(b_done), .err(b_err));

  // Output vector encodings {c_load,conv,tree,pool,cout_done,done,busy,err}
  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LOAD = 8'b1000_0010;
  localparam logic [7:0] O_CONV = 8'b0100_0010;
  localparam logic [7:0] O_WAIT = 8'b0000_0010;
  localparam logic [7:0] O_TREE = 8'b0010_0010;
  localparam logic [7:0] O_NEXT = 8'b0000_1010;
  localparam logic [7:0] O_DONE = 8'b0000_0110;
  localparam logic [7:0] O_ERR  = 8'b0000_0011;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard on A's command stream ----------------
  localparam int K_LOAD = 0, K_CONV = 1, K_TREE = 2, K_POOL = 3, K_COUT = 4, K_DONE = 5;
  typedef struct { int kind; int oc; int ic; } ev_t;  // oc/ic < 0 : don't care
  ev_t sbq[$];
  bit  mon_on = 1'b0;
  int  cnt_conv, cnt_tree, cnt_pool, cnt_cout, cnt_done;

  task automatic push_layer(input bit p);
    for (int o = 0; o < 8; o++) begin
      sbq.push_back('{K_LOAD, o, 0});
      for (int i = 0; i < 4; i++) sbq.push_back('{K_CONV, o, i});
      sbq.push_back('{K_TREE, o, 3});
      if (p) sbq.push_back('{K_POOL, o, -1});
      sbq.push_back('{K_COUT, o, -1});
    end
    sbq.push_back('{K_DONE, -1, -1});
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_on && (a_vec[7:2] != 6'd0)) begin
      int  k;
      ev_t e;
      chk("pulse_onehot", $countones(a_vec[7:2]), 1);
      chk("pulse_busy", int'(a_busy), 1);
      if (a_c_load) k = K_LOAD;
      else if (a_conv) begin k = K_CONV; cnt_conv++; end
      else if (a_tree) begin k = K_TREE; cnt_tree++; end
      else if (a_pool) begin k = K_POOL; cnt_pool++; end
      else if (a_cout_done) begin k = K_COUT; cnt_cout++; end
      else begin k = K_DONE; cnt_done++; end
      if (sbq.size() == 0) begin
        chk("sb_unexpected_event", k, -1);
      end else begin
        e = sbq.pop_front();
        chk("sb_kind", k, e.kind);
        if (e.oc >= 0) chk("sb_oc_idx", int'(a_oc_idx), e.oc);
        if (e.ic >= 0) chk("sb_ic_idx", int'(a_ic_idx), e.ic);
      end
    end
  end

  // ---------------- engine responders for A ----------------
  // c_mode: 0 idle low, 1 random 1..20 cycle delay after conv, 2 held high
  int c_mode = 0, p_mode = 0, p_block_oc = -1;
  int c_dly, p_dly;

  initial forever begin
    @(negedge clk);
    a_conv_done = (c_mode == 2);
    if (c_mode == 1 && a_conv) begin
      c_dly = $urandom_range(20, 1);
      repeat (c_dly) @(negedge clk);
      a_conv_done = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    a_pool_done = 1'b0;
    if (p_mode == 1 && a_pool && int'(a_oc_idx) != p_block_oc) begin
      p_dly = $urandom_range(20, 1);
      repeat (p_dly) @(negedge clk);
      a_pool_done = 1'b1;
    end
  end

  // Runs one layer on A; exp_cyc > 0 checks the start-to-done latency exactly.
  task automatic run_layer(input bit p, input int exp_cyc, input string tag);
    int cyc;
    push_layer(p);
    cnt_conv = 0; cnt_tree = 0; cnt_pool = 0; cnt_cout = 0; cnt_done = 0;
    @(negedge clk);
    a_start = 1'b1;
    a_pool_en = p;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        a_start = 1'b0;
        a_pool_en = !p;  // must not affect the running layer
      end
    end while (!a_done && cyc < 6000);
    chk({tag, "_done_seen"}, int'(a_done), 1);
    if (exp_cyc > 0) chk({tag, "_latency"}, cyc, exp_cyc);
    @(negedge clk);
    chk({tag, "_conv_cnt"}, cnt_conv, 32);
    chk({tag, "_tree_cnt"}, cnt_tree, 8);
    chk({tag, "_pool_cnt"}, cnt_pool, p ? 8 : 0);
    chk({tag, "_cout_cnt"}, cnt_cout, 8);
    chk({tag, "_done_cnt"}, cnt_done, 1);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    chk({tag, "_idle_after"}, int'({a_vec, a_oc_idx, a_ic_idx}), 0);
  endtask

  // ---------------- vector table for B ----------------
  typedef struct { logic start; logic cdone; logic abort; logic [7:0] exp; } vec_t;
  vec_t vt[20];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    // Row k: expected outputs during cycle k, inputs driven during cycle k.
    vt[0]  = '{1'b1, 1'b0, 1'b0, O_IDLE};
    vt[1]  = '{1'b0, 1'b0, 1'b0, O_LOAD};
    vt[2]  = '{1'b0, 1'b0, 1'b0, O_CONV};
    vt[3]  = '{1'b0, 1'b1, 1'b0, O_WAIT};
    vt[4]  = '{1'b0, 1'b0, 1'b0, O_TREE};
    vt[5]  = '{1'b0, 1'b0, 1'b0, O_NEXT};
    vt[6]  = '{1'b0, 1'b0, 1'b0, O_DONE};   // 6 cycles after start
    vt[7]  = '{1'b1, 1'b0, 1'b1, O_IDLE};   // start+abort together
    vt[8]  = '{1'b0, 1'b0, 1'b0, O_IDLE};
    vt[9]  = '{1'b1, 1'b0, 1'b0, O_IDLE};
    vt[10] = '{1'b0, 1'b1, 1'b0, O_LOAD};   // conv_done outside WAIT_C ignored
    vt[11] = '{1'b0, 1'b1, 1'b0, O_CONV};
    vt[12] = '{1'b0, 1'b0, 1'b0, O_WAIT};
    vt[13] = '{1'b0, 1'b1, 1'b0, O_WAIT};
    vt[14] = '{1'b0, 1'b0, 1'b0, O_TREE};
    vt[15] = '{1'b0, 1'b0, 1'b0, O_NEXT};
    vt[16] = '{1'b0, 1'b0, 1'b0, O_DONE};
    vt[17] = '{1'b1, 1'b0, 1'b0, O_IDLE};
    vt[18] = '{1'b0, 1'b0, 1'b1, O_LOAD};   // abort from LOAD
    vt[19] = '{1'b0, 1'b0, 1'b0, O_IDLE};

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("rst_a_outputs", int'({a_vec, a_oc_idx, a_ic_idx}), 0);
    chk("rst_b_outputs", int'({b_vec, b_oc_idx, b_ic_idx}), 0);
    rst_n = 1'b1;

    // B: cycle-exact table
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), int'({b_vec, b_oc_idx, b_ic_idx}), int'({vt[i].exp, 2'b00}));
      b_start = vt[i].start;
      b_conv_done = vt[i].cdone;
      b_abort = vt[i].abort;
    end
    @(negedge clk);
    b_start = 1'b0; b_conv_done = 1'b0; b_abort = 1'b0;

    // B: watchdog trips 16 cycles after entering WAIT_C (cycle 3 -> ERR at 19)
    b_start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) b_start = 1'b0;
    end
    chk("wd_before_trip", int'(b_vec), int'(O_WAIT));
    @(negedge clk);
    chk("wd_trip", int'(b_vec), int'(O_ERR));
    b_start = 1'b1;  // ignored while busy
    repeat (4) @(negedge clk);
    chk("wd_err_held", int'(b_vec), int'(O_ERR));
    b_start = 1'b0;
    b_abort = 1'b1;
    @(negedge clk);
    b_abort = 1'b0;
    chk("wd_abort_clears", int'({b_vec, b_oc_idx, b_ic_idx}), 0);

    // B: conv_done on the final watchdog cycle wins over the timeout
    @(negedge clk);
    b_start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) b_start = 1'b0;
    end
    b_conv_done = 1'b1;
    @(negedge clk);
    b_conv_done = 1'b0;
    chk("wd_done_wins", int'(b_vec), int'(O_TREE));
    repeat (2) @(negedge clk);
    chk("wd_done_wins_done", int'(b_vec), int'(O_DONE));
    @(negedge clk);
    chk("wd_done_wins_idle", int'(b_vec), int'(O_IDLE));

    // A: synchronous reset held two cycles in the middle of WAIT_C
    begin
      int c;
      c_mode = 0;
      a_start = 1'b1;
      c = 0;
      do begin
        @(negedge clk);
        c++;
        a_start = 1'b0;
      end while (!a_conv && c < 20);
      chk("rst_mid_conv_seen", int'(a_conv), 1);
      @(negedge clk);
      chk("rst_mid_in_wait", int'(a_vec), int'(O_WAIT));
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid_outputs", int'({a_vec, a_oc_idx, a_ic_idx}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mid_stays_idle", int'({a_vec, a_oc_idx, a_ic_idx}), 0);
    end

    // A: full layer with pooling and random engine latencies
    mon_on = 1'b1;
    c_mode = 1; p_mode = 1;
    run_layer(1'b1, 0, "layer_rand");

    // A: conv_done stuck high -> one ic step per WAIT_C, exact latency 8*11+1
    c_mode = 2;
    run_layer(1'b0, 89, "layer_held");
    c_mode = 1;
    @(negedge clk);

    // A: abort while waiting on pool for oc 3
    begin
      int c;
      p_block_oc = 3;
      push_layer(1'b1);
      cnt_conv = 0; cnt_tree = 0; cnt_pool = 0; cnt_cout = 0; cnt_done = 0;
      a_start = 1'b1;
      a_pool_en = 1'b1;
      c = 0;
      do begin
        @(negedge clk);
        c++;
        a_start = 1'b0;
      end while (!(a_pool && a_oc_idx == 3'd3) && c < 3000);
      chk("abort_pool3_seen", int'(a_pool && a_oc_idx == 3'd3), 1);
      @(negedge clk);
      chk("abort_in_wait_p", int'(a_vec), int'(O_WAIT));
      a_abort = 1'b1;
      @(negedge clk);
      a_abort = 1'b0;
      chk("abort_idle", int'({a_vec, a_oc_idx, a_ic_idx}), 0);
      repeat (4) @(negedge clk);
      chk("abort_cout_cnt", cnt_cout, 3);
      chk("abort_done_cnt", cnt_done, 0);
      chk("abort_next_pending_kind", sbq.size() > 0 ? sbq[0].kind : -1, K_COUT);
      chk("abort_next_pending_oc", sbq.size() > 0 ? sbq[0].oc : -1, 3);
      sbq.delete();
      p_block_oc = -1;
    end
    run_layer(1'b0, 0, "layer_after_abort");

    mon_on = 1'b0;
    c_mode = 0; p_mode = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
